// File: rtl/dac_lane_mapper_if.sv
// Sample-side and DAC-side handshake bundle for dac_lane_mapper.
// Signal names follow the original port names so existing connections carry over.
interface dac_lane_mapper_if #(
   parameter int unsigned NCH  = 2,
   parameter int unsigned NSMP = 4,
   parameter int unsigned SW   = 16
);
   localparam int unsigned W = NCH * NSMP * SW;

   logic [W-1:0] DATA_I;
   logic         VALID_I;
   logic         READY_O;
   logic [1:0]   MODE_I;
   logic         FMT_OB_I;
   logic         CLR_I;
   logic [W-1:0] DATA_O;
   logic         VALID_O;
   logic         READY_I;
   logic         UNDERRUN_O;

   modport master (
      output DATA_I, VALID_I, MODE_I, FMT_OB_I, CLR_I, READY_I,
      input  READY_O, DATA_O, VALID_O, UNDERRUN_O
   );

   modport slave (
      input  DATA_I, VALID_I, MODE_I, FMT_OB_I, CLR_I, READY_I,
      output READY_O, DATA_O, VALID_O, UNDERRUN_O
   );
endinterface

// File: rtl/dac_lane_mapper.sv
// Registered sample-to-lane mapper with 2-entry skid buffer, ramp/midscale test
// patterns, offset-binary option and sticky underrun monitor.
module dac_lane_mapper #(
   parameter int unsigned NCH  = 2,
   parameter int unsigned NSMP = 4,
   parameter int unsigned SW   = 16
) (
   input  logic              CLK_I,
   input  logic              RST_N_I,
   dac_lane_mapper_if.slave  bus
);
   localparam int unsigned HW = SW / 2;
   localparam int unsigned W  = NCH * NSMP * SW;

   typedef enum logic [1:0] {
      MODE_SPLIT    = 2'd0,
      MODE_STRAIGHT = 2'd1,
      MODE_MID      = 2'd2,
      MODE_RAMP     = 2'd3
   } mode_e;

   logic [W-1:0]  out_data_q,  out_data_d;
   logic          out_valid_q, out_valid_d;
   logic [W-1:0]  skid_data_q, skid_data_d;
   logic          skid_valid_q, skid_valid_d;
   logic          ready_q,     ready_d;
   logic [SW-1:0] ramp_q,      ramp_d;
   logic          first_q,     first_d;
   logic          underrun_q,  underrun_d;

   logic          accept;
   logic          drain;
   logic [SW-1:0] ramp_use;
   logic [W-1:0]  mapped;
   mode_e         mode;

   // Channel 0 lands in the most significant group; byte-split puts all high
   // halves of a channel above all its low halves.
   function automatic logic [W-1:0] map_beat(
      input logic [W-1:0]  din,
      input mode_e         md,
      input logic          fmt_ob,
      input logic [SW-1:0] ramp
   );
      logic [W-1:0]  res;
      logic [SW-1:0] v;
      int unsigned   base;
      res = '0;
      for (int unsigned c = 0; c < NCH; c++) begin
         for (int unsigned p = 0; p < NSMP; p++) begin
            case (md)
               MODE_SPLIT, MODE_STRAIGHT: v = din[(c*NSMP + p)*SW +: SW];
               MODE_MID:                  v = '0;
               default:                   v = ramp + SW'(p);
            endcase
            v[SW-1] = v[SW-1] ^ fmt_ob;
            base = (NCH - 1 - c) * NSMP * SW;
            if (md == MODE_STRAIGHT) begin
               res[base + p*SW +: SW] = v;
            end else begin
               res[base + NSMP*HW + p*HW +: HW] = v[SW-1:HW];
               res[base + p*HW +: HW]           = v[HW-1:0];
            end
         end
      end
      return res;
   endfunction

   always_comb begin
      mode     = mode_e'(bus.MODE_I);
      accept   = bus.VALID_I & ready_q;
      drain    = out_valid_q & bus.READY_I;
      ramp_use = bus.CLR_I ? '0 : ramp_q;
      mapped   = map_beat(bus.DATA_I, mode, bus.FMT_OB_I, ramp_use);

      out_data_d   = out_data_q;
      out_valid_d  = out_valid_q;
      skid_data_d  = skid_data_q;
      skid_valid_d = skid_valid_q;
      ramp_d       = ramp_use;

      if (accept && mode == MODE_RAMP) begin
         ramp_d = ramp_use + SW'(NSMP);
      end

      // An accept only happens with the skid empty, so it never races a
      // skid-to-output move.
      if (accept) begin
         if (!out_valid_q || drain) begin
            out_data_d  = mapped;
            out_valid_d = 1'b1;
         end else begin
            skid_data_d  = mapped;
            skid_valid_d = 1'b1;
         end
      end else if (drain) begin
         if (skid_valid_q) begin
            out_data_d   = skid_data_q;
            skid_valid_d = 1'b0;
         end else begin
            out_valid_d = 1'b0;
         end
      end

      ready_d    = ~skid_valid_d;
      first_d    = bus.CLR_I ? 1'b0 : (first_q | drain);
      underrun_d = bus.CLR_I ? 1'b0
                 : (underrun_q | (first_q & bus.READY_I & ~out_valid_q));
   end

   always_ff @(posedge CLK_I) begin
      if (!RST_N_I) begin
         out_data_q   <= '0;
         out_valid_q  <= 1'b0;
         skid_data_q  <= '0;
         skid_valid_q <= 1'b0;
         ready_q      <= 1'b0;
         ramp_q       <= '0;
         first_q      <= 1'b0;
         underrun_q   <= 1'b0;
      end else begin
         out_data_q   <= out_data_d;
         out_valid_q  <= out_valid_d;
         skid_data_q  <= skid_data_d;
         skid_valid_q <= skid_valid_d;
         ready_q      <= ready_d;
         ramp_q       <= ramp_d;
         first_q      <= first_d;
         underrun_q   <= underrun_d;
      end
   end

   assign bus.DATA_O     = out_data_q;
   assign bus.VALID_O    = out_valid_q;
   assign bus.READY_O    = ready_q;
   assign bus.UNDERRUN_O = underrun_q;
endmodule

// File: tb/tb_dac_lane_mapper.sv
// Directed bench for dac_lane_mapper: mapping table, ramp/clear, underrun,
// backpressure ordering and mid-stream reset.
module tb_dac_lane_mapper;
   localparam int unsigned NCH  = 2;
   localparam int unsigned NSMP = 4;
   localparam int unsigned SW   = 16;
   localparam int unsigned W    = NCH * NSMP * SW;

   typedef struct {
      string        name;
      logic [1:0]   mode;
      logic         fmt;
      logic [W-1:0] din;
      logic [W-1:0] exp;
   } vec_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   dac_lane_mapper_if #(.NCH(NCH), .NSMP(NSMP), .SW(SW)) bus ();

   dac_lane_mapper #(.NCH(NCH), .NSMP(NSMP), .SW(SW)) dut (
      .CLK_I   (clk),
      .RST_N_I (rst_n),
      .bus     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [W-1:0] ramp_exp(input int r);
      logic [63:0] g;
      g = {32'h0, 8'(r + 3), 8'(r + 2), 8'(r + 1), 8'(r)};
      return {g, g};
   endfunction

   function automatic logic [W-1:0] bp_din(input int i);
      logic [W-1:0] d;
      for (int j = 0; j < 8; j++) d[j*16 +: 16] = 16'(i*256 + j);
      return d;
   endfunction

   function automatic logic [W-1:0] bp_exp(input int i);
      logic [W-1:0] e;
      for (int p = 0; p < 4; p++) begin
         e[64 + p*16 +: 16] = 16'(i*256 + p);
         e[p*16 +: 16]      = 16'(i*256 + 4 + p);
      end
      return e;
   endfunction

   vec_t        vecs[6];
   logic [W-1:0] base_din;
   logic [15:0]  rpat;
   int           sent, recv, occ, ph;
   logic         exp_rdy, acc, drn;

   initial begin
      checks = 0;
      errors = 0;
      base_din = {64'hABCDABCDABCDABCD, 64'h7788556633441122};
      vecs[0] = '{"split_fmt0",    2'd0, 1'b0, base_din, {64'h7755331188664422, 64'hABABABABCDCDCDCD}};
      vecs[1] = '{"straight_fmt0", 2'd1, 1'b0, base_din, {64'h7788556633441122, 64'hABCDABCDABCDABCD}};
      vecs[2] = '{"straight_fmt1", 2'd1, 1'b1, base_din, {64'hF788D566B3449122, 64'h2BCD2BCD2BCD2BCD}};
      vecs[3] = '{"split_fmt1",    2'd0, 1'b1, base_din, {64'hF7D5B39188664422, 64'h2B2B2B2BCDCDCDCD}};
      vecs[4] = '{"mid_fmt0",      2'd2, 1'b0, base_din, '0};
      vecs[5] = '{"mid_fmt1",      2'd2, 1'b1, base_din, {64'h8080808000000000, 64'h8080808000000000}};

      rst_n        = 1'b0;
      bus.DATA_I   = '0;
      bus.VALID_I  = 1'b0;
      bus.MODE_I   = 2'd0;
      bus.FMT_OB_I = 1'b0;
      bus.CLR_I    = 1'b0;
      bus.READY_I  = 1'b0;

      // Reset values and release
      repeat (3) @(negedge clk);
      chk("rst_data", bus.DATA_O, '0);
      chk("rst_valid", W'(bus.VALID_O), '0);
      chk("rst_ready", W'(bus.READY_O), '0);
      chk("rst_underrun", W'(bus.UNDERRUN_O), '0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_release", W'(bus.READY_O), W'(1));

      // Mapping table
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         bus.MODE_I   = vecs[i].mode;
         bus.FMT_OB_I = vecs[i].fmt;
         bus.DATA_I   = vecs[i].din;
         bus.VALID_I  = 1'b1;
         bus.READY_I  = 1'b1;
         @(negedge clk);
         bus.VALID_I = 1'b0;
         chk(vecs[i].name, bus.DATA_O, vecs[i].exp);
         chk({vecs[i].name, "_valid"}, W'(bus.VALID_O), W'(1));
      end

      // Ramp back-to-back, then clear coinciding with an accepted beat
      @(negedge clk);
      bus.CLR_I = 1'b1;
      @(negedge clk);
      bus.CLR_I    = 1'b0;
      bus.MODE_I   = 2'd3;
      bus.FMT_OB_I = 1'b0;
      bus.VALID_I  = 1'b1;
      for (int b = 0; b < 3; b++) begin
         @(negedge clk);
         chk($sformatf("ramp_beat%0d", b), bus.DATA_O, ramp_exp(4*b));
      end
      bus.CLR_I = 1'b1;
      @(negedge clk);
      bus.CLR_I = 1'b0;
      chk("ramp_clr_beat", bus.DATA_O, ramp_exp(0));
      @(negedge clk);
      bus.VALID_I = 1'b0;
      chk("ramp_after_clr", bus.DATA_O, ramp_exp(4));

      // Underrun: set one edge after the first emitted beat, sticky, cleared by CLR_I
      @(negedge clk);
      bus.CLR_I = 1'b1;
      @(negedge clk);
      bus.CLR_I = 1'b0;
      chk("ur_cleared", W'(bus.UNDERRUN_O), '0);
      bus.MODE_I  = 2'd0;
      bus.DATA_I  = base_din;
      bus.VALID_I = 1'b1;
      @(negedge clk);
      bus.VALID_I = 1'b0;
      chk("ur_beat_valid", W'(bus.VALID_O), W'(1));
      chk("ur_before_emit", W'(bus.UNDERRUN_O), '0);
      @(negedge clk);
      chk("ur_at_emit", W'(bus.UNDERRUN_O), '0);
      @(negedge clk);
      chk("ur_set", W'(bus.UNDERRUN_O), W'(1));
      repeat (3) @(negedge clk);
      chk("ur_sticky", W'(bus.UNDERRUN_O), W'(1));
      bus.CLR_I = 1'b1;
      @(negedge clk);
      bus.CLR_I = 1'b0;
      chk("ur_clr", W'(bus.UNDERRUN_O), '0);
      repeat (2) @(negedge clk);
      chk("ur_stays_clear", W'(bus.UNDERRUN_O), '0);

      // Backpressure with an occupancy model of the two-entry buffer
      rpat         = 16'b1110011100111001;
      ph           = int'($urandom_range(0, 15));
      sent         = 0;
      recv         = 0;
      occ          = 0;
      exp_rdy      = 1'b1;
      bus.MODE_I   = 2'd1;
      bus.FMT_OB_I = 1'b0;
      for (int cyc = 0; cyc < 400 && recv < 20; cyc++) begin
         @(negedge clk);
         bus.READY_I = rpat[(cyc + ph) % 16];
         bus.VALID_I = (sent < 20);
         bus.DATA_I  = bp_din(sent);
         chk("bp_ready", W'(bus.READY_O), W'(exp_rdy));
         chk("bp_valid", W'(bus.VALID_O), W'(occ > 0));
         acc = bus.VALID_I && exp_rdy;
         drn = (occ > 0) && bus.READY_I;
         if (drn) begin
            chk($sformatf("bp_data%0d", recv), bus.DATA_O, bp_exp(recv));
            recv++;
         end
         if (acc) sent++;
         occ = occ + int'(acc) - int'(drn);
         exp_rdy = (occ < 2);
      end
      chk("bp_count", W'(recv), W'(20));
      @(negedge clk);
      bus.VALID_I = 1'b0;
      bus.READY_I = 1'b1;
      repeat (2) @(negedge clk);

      // Reset with the skid register full
      bus.READY_I = 1'b0;
      bus.MODE_I  = 2'd0;
      bus.DATA_I  = vecs[0].din;
      bus.VALID_I = 1'b1;
      @(negedge clk);
      bus.DATA_I = bp_din(7);
      @(negedge clk);
      bus.VALID_I = 1'b0;
      chk("skid_full_ready", W'(bus.READY_O), '0);
      chk("skid_full_valid", W'(bus.VALID_O), W'(1));
      rst_n = 1'b0;
      @(negedge clk);
      chk("mrst_data", bus.DATA_O, '0);
      chk("mrst_valid", W'(bus.VALID_O), '0);
      chk("mrst_ready", W'(bus.READY_O), '0);
      chk("mrst_underrun", W'(bus.UNDERRUN_O), '0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("mrst_ready_release", W'(bus.READY_O), W'(1));
      bus.READY_I = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("mrst_no_stale", W'(bus.VALID_O), '0);
         chk("mrst_no_underrun", W'(bus.UNDERRUN_O), '0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/dac_lane_mapper.md
# dac_lane_mapper

Registered, parametrised sample-to-lane mapper between the AWG sample pipeline and the DAC transmit interface. It reorders NCH channels × NSMP samples of SW bits into the DAC lane word. It supports byte-split and straight layouts, an optional offset-binary conversion, and built-in midscale/ramp test patterns. It adds a valid/ready handshake with a 2-entry skid buffer, so backpressure from the DAC interface never drops a beat, and a sticky underrun monitor.

## Interface
- NCH, 2: channel count (≥1)
- NSMP, 4: samples per channel per beat (≥1)
- SW, 16: sample width in bits (even, ≥4); HW = SW/2
- CLK_I  in  1  clock; all logic on rising edge
- RST_N_I  in  1  reset, synchronous, active-low
- DATA_I  in  NCH·NSMP·SW  input beat; slot j = DATA_I[j·SW +: SW], channel c = j/NSMP, position p = j%NSMP
- VALID_I  in  1  input beat valid
- READY_O  out  1  block can accept a beat
- MODE_I  in  2  0 byte-split, 1 straight, 2 midscale test, 3 ramp test; sampled on acceptance
- FMT_OB_I  in  1  1 = invert sample MSB (two's complement → offset binary); sampled on acceptance
- CLR_I  in  1  synchronous clear of ramp counter and UNDERRUN_O
- DATA_O  out  NCH·NSMP·SW  mapped lane word
- VALID_O  out  1  DATA_O valid
- READY_I  in  1  DAC interface accepts DATA_O
- UNDERRUN_O  out  1  sticky: DAC was ready while no data was held

## Operation
- Accept on VALID_I & READY_O; emit on VALID_O & READY_I.
- Per-sample value v(c,p) is determined by the mode sampled at acceptance:
  - modes 0/1: the input slot value.
  - mode 2: 0.
  - mode 3: (ramp + p) mod 2^SW, identical for all channels.
  - If FMT_OB_I = 1, v[SW-1] is inverted after the value is chosen.
- Channel group placement: channel c occupies G_c = DATA_O[(NCH-1-c)·NSMP·SW +: NSMP·SW]. Channel 0 is most significant.
- Byte-split (modes 0, 2, 3): G_c = {H_c, L_c}.
  - H_c[p·HW +: HW] = v(c,p)[SW-1:HW]
  - L_c[p·HW +: HW] = v(c,p)[HW-1:0]
- Straight (mode 1): G_c[p·SW +: SW] = v(c,p).
- Ramp counter, SW bits:
  - += NSMP, wrapping, on each accepted beat in mode 3.
  - Held in the other modes.
  - Set to 0 by reset or CLR_I. If CLR_I and an accept occur in the same cycle, that beat uses 0 and the counter becomes NSMP.
- Buffering: main output register plus one skid register.
  - READY_O = registered "skid empty".
  - An accept while the output register is full and not draining loads the skid register. READY_O drops the next cycle.
  - A drain with the skid full moves skid → output. READY_O rises the next cycle.
  - Beat order is strictly preserved. No beat is lost or duplicated.
- Underrun: after the first beat since reset/CLR_I has been emitted, any cycle with READY_I = 1 and VALID_O = 0 sets UNDERRUN_O. It stays set until CLR_I or reset. CLR_I wins over a same-cycle set.
- Mode/format changes take effect per beat. No flush is required, and beats already buffered keep their original mapping.

## Timing
- Reset (RST_N_I = 0 at an edge) drives at that edge:
  - DATA_O = 0, VALID_O = 0, READY_O = 0, UNDERRUN_O = 0
  - skid register empty, ramp counter = 0, first-beat flag clear
- READY_O = 1 on the first edge after RST_N_I returns high.
- Reset mid-operation discards all buffered beats and is not an underrun.
- Latency: a beat accepted at edge k is on DATA_O with VALID_O = 1 after edge k when the output register is empty or draining.
- Throughput: 1 beat/cycle with READY_I held high.
- DATA_O is held stable while VALID_O & !READY_I.
- Mapping is purely combinational ahead of the output register. There are no combinational paths from input to output or from READY_I to READY_O.

## Test plan
- Byte-split, defaults, FMT_OB_I = 0: channel 0 slots p0..p3 = 0x1122, 0x3344, 0x5566, 0x7788, channel 1 all 0xABCD -> after one cycle:
  - DATA_O[127:64] = 0x7755331188664422
  - DATA_O[63:0] = 0xABABABABCDCDCDCD
- Straight mode with the same input -> DATA_O[127:64] = 0x7788556633441122 and DATA_O[63:0] = 0xABCDABCDABCDABCD. Repeat with FMT_OB_I = 1 -> every sample MSB flipped; channel 0 p0 becomes 0x9122.
- Ramp mode, 3 beats back-to-back with READY_I = 1:
  - beat 0 samples = 0, 1, 2, 3; beat 2 samples = 8..11.
  - Assert CLR_I and continue -> next beat restarts at 0.
- Backpressure: stream 20 incrementing beats while READY_I follows a random pattern with 2-cycle low runs -> READY_O drops one cycle after the skid register fills; all 20 beats arrive in order with no duplicates.
- Underrun: emit one beat, then hold VALID_I = 0 and READY_I = 1 -> UNDERRUN_O = 1 one edge later and stays set; CLR_I clears it.
- Reset mid-stream with skid full -> all outputs return to reset values; READY_O = 1 one edge after release; no stale beat is emitted.
